// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stall/flush scheduler.
package pipe_pkg;

  // Architectural register index width (x0..x31).
  localparam int REG_ADDR_W = 5;

  // Default number of cycles a mul/div instruction occupies EX.
  localparam int MDU_CYCLES_DEF = 4;

  // MDU sequencer states: RUN is normal flow, MDU_WAIT holds EX for the MDU op.
  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MDU_WAIT = 1'b1
  } mdu_state_e;

endpackage : pipe_pkg

// File: rtl/pipe_ctrl_if.sv
// Hazard inputs and pipeline-register control outputs of the stall/flush
// scheduler. The master side is the core datapath, the slave side is pipe_ctrl.
interface pipe_ctrl_if #(
  parameter int STALL_CNT_W = 32
) ();
  import pipe_pkg::*;

  logic [REG_ADDR_W-1:0]  rs1_ID;
  logic [REG_ADDR_W-1:0]  rs2_ID;
  logic                   use_rs1_ID;
  logic                   use_rs2_ID;
  logic                   branch_ID;
  logic                   taken_ID;
  logic [REG_ADDR_W-1:0]  rd_EX;
  logic [REG_ADDR_W-1:0]  rd_MEM;
  logic                   MemRead_EX;
  logic                   MemRead_MEM;
  logic                   mdu_req_EX;

  logic                   stall_PC;
  logic                   stall_IFID;
  logic                   stall_IDEX;
  logic                   flush_IFID;
  logic                   flush_IDEX;
  logic                   flush_EXMEM;
  logic                   mdu_done;
  logic                   busy;
  logic [STALL_CNT_W-1:0] stall_cycles;

  modport master (
    output rs1_ID, rs2_ID, use_rs1_ID, use_rs2_ID, branch_ID, taken_ID,
           rd_EX, rd_MEM, MemRead_EX, MemRead_MEM, mdu_req_EX,
    input  stall_PC, stall_IFID, stall_IDEX, flush_IFID, flush_IDEX,
           flush_EXMEM, mdu_done, busy, stall_cycles
  );

  modport slave (
    input  rs1_ID, rs2_ID, use_rs1_ID, use_rs2_ID, branch_ID, taken_ID,
           rd_EX, rd_MEM, MemRead_EX, MemRead_MEM, mdu_req_EX,
    output stall_PC, stall_IFID, stall_IDEX, flush_IFID, flush_IDEX,
           flush_EXMEM, mdu_done, busy, stall_cycles
  );

endinterface : pipe_ctrl_if

// File: rtl/pipe_ctrl_mdu_seq.sv
// MDU occupancy sequencer: tracks how long a mul/div instruction has held EX,
// requests the freeze of IF/ID/EX and pulses mdu_done on its last EX cycle.
// Optional feature macro: PIPE_CTRL_MDU_EN (undefined -> sequencer fixed at RUN).
module pipe_ctrl_mdu_seq
  import pipe_pkg::*;
#(
  parameter int MDU_CYCLES = MDU_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic mdu_req,
  output logic mdu_stall,
  output logic mdu_done,
  output logic busy
);

`ifdef PIPE_CTRL_MDU_EN
  // Remaining wait cycles; the entry cycle is spent in RUN, so the load
  // value is two less than the total occupancy.
  localparam int              CNT_W    = $clog2(MDU_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_CYCLES - 2);

  mdu_state_e       state_q;
  mdu_state_e       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // State and countdown registers; reset aborts any MDU operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and stall request: start on a request seen in RUN, hold while
  // the countdown is non-zero, then release with a one-cycle done pulse.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mdu_stall = 1'b0;
    mdu_done  = 1'b0;
    unique case (state_q)
      RUN: begin
        if (mdu_req) begin
          mdu_stall = 1'b1;
          cnt_d     = CNT_LOAD;
          state_d   = MDU_WAIT;
        end
      end
      MDU_WAIT: begin
        if (cnt_q != '0) begin
          mdu_stall = 1'b1;
          cnt_d     = cnt_q - CNT_W'(1);
        end else begin
          mdu_done  = 1'b1;
          state_d   = RUN;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  assign busy = (state_q != RUN);
`else
  // Without the MDU the sequencer never leaves RUN and the request is ignored.
  mdu_state_e state_q;
  logic       unused_inputs;

  assign state_q       = RUN;
  assign busy          = (state_q != RUN);
  assign mdu_stall     = 1'b0;
  assign mdu_done      = 1'b0;
  assign unused_inputs = ^{clk, rst, mdu_req, MDU_CYCLES[0]};
`endif

endmodule : pipe_ctrl_mdu_seq

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush scheduler for the 5-stage core. Resolves the hazards
// forwarding cannot: load-use, branch-in-ID waiting on a load in MEM, taken
// redirects from ID and multi-cycle MDU occupancy of EX.
// Optional feature macro: PIPE_CTRL_MDU_EN (enables the MDU sequencer).
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int MDU_CYCLES  = MDU_CYCLES_DEF,
  parameter int STALL_CNT_W = 32
) (
  input logic        clk,
  input logic        rst,
  pipe_ctrl_if.slave bus
);

  logic                   mdu_stall;
  logic                   mdu_done;
  logic                   mdu_busy;
  logic                   lu;
  logic                   bl;
  logic                   rd_ex_hit;
  logic                   rd_mem_hit;
  logic                   stall_pc;
  logic                   stall_ifid;
  logic                   stall_idex;
  logic                   flush_ifid;
  logic                   flush_idex;
  logic                   flush_exmem;
  logic [STALL_CNT_W-1:0] stall_cnt_q;

  pipe_ctrl_mdu_seq #(
    .MDU_CYCLES (MDU_CYCLES)
  ) u_mdu_seq (
    .clk       (clk),
    .rst       (rst),
    .mdu_req   (bus.mdu_req_EX),
    .mdu_stall (mdu_stall),
    .mdu_done  (mdu_done),
    .busy      (mdu_busy)
  );

  // Hazard detection: a load result is only needed if ID really reads that
  // register and it is not x0. ALU producers are forwarded and never stall.
  always_comb begin
    rd_ex_hit  = (bus.rd_EX != '0) &&
                 ((bus.use_rs1_ID && (bus.rd_EX == bus.rs1_ID)) ||
                  (bus.use_rs2_ID && (bus.rd_EX == bus.rs2_ID)));
    rd_mem_hit = (bus.rd_MEM != '0) &&
                 ((bus.use_rs1_ID && (bus.rd_MEM == bus.rs1_ID)) ||
                  (bus.use_rs2_ID && (bus.rd_MEM == bus.rs2_ID)));
    lu         = bus.MemRead_EX && rd_ex_hit;
    bl         = bus.branch_ID && bus.MemRead_MEM && rd_mem_hit;
  end

  // Priority mux: MDU freeze beats load hazards, which beat a redirect; a
  // redirect seen during any stall is dropped because ID resolves it again.
  always_comb begin
    stall_pc    = 1'b0;
    stall_ifid  = 1'b0;
    stall_idex  = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    flush_exmem = 1'b0;
    if (mdu_stall) begin
      stall_pc    = 1'b1;
      stall_ifid  = 1'b1;
      stall_idex  = 1'b1;
      flush_exmem = 1'b1;
    end else if (lu || bl) begin
      stall_pc    = 1'b1;
      stall_ifid  = 1'b1;
      flush_idex  = 1'b1;
    end else if (bus.taken_ID) begin
      flush_ifid  = 1'b1;
    end
  end

  // Saturating performance counter of cycles in which the PC was held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (stall_pc && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  // Controls are forced quiet while reset is held, whatever the inputs say.
  assign bus.stall_PC     = !rst && stall_pc;
  assign bus.stall_IFID   = !rst && stall_ifid;
  assign bus.stall_IDEX   = !rst && stall_idex;
  assign bus.flush_IFID   = !rst && flush_ifid;
  assign bus.flush_IDEX   = !rst && flush_idex;
  assign bus.flush_EXMEM  = !rst && flush_exmem;
  assign bus.mdu_done     = !rst && mdu_done;
  assign bus.busy         = !rst && mdu_busy;
  assign bus.stall_cycles = stall_cnt_q;

endmodule : pipe_ctrl
